iomem_rgb_pwm: RTL and testbench



---
 rtl/iomem_rgb_pwm.sv | 124 ++++++++++++
 tb/tb_iomem_rgb_pwm.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_rgb_pwm.sv
// PicoSoC iomem-mapped 8-bit RGB PWM generator feeding SB_RGBA_DRV.
// Duty writes land in a shadow register and reach the outputs at the next period wrap.
module iomem_rgb_pwm #(
  parameter logic [7:0]  BASE_ADDR  = 8'h03,
  parameter logic [23:0] DUTY_RESET = 24'h000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        pwm_r,
  output logic        pwm_g,
  output logic        pwm_b,
  output logic        period_irq
);

  logic        en, inv, pend;
  logic [15:0] presc, presc_cnt, pcount;
  logic [7:0]  phase;
  logic [23:0] shadow, active;
  logic        wrap_p0;

  logic        sel, wr_ctrl, wr_duty, tick, wrap;
  logic [1:0]  idx;
  logic [23:0] shadow_nxt;
  logic [31:0] rd_mux;

  logic unused_bits;
  assign unused_bits = ^{iomem_addr[23:4], iomem_addr[1:0], iomem_wdata[31:24], iomem_wdata[15:2]};

  assign sel     = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_ADDR);
  assign idx     = iomem_addr[3:2];
  assign wr_ctrl = sel && (|iomem_wstrb) && (idx == 2'd0);
  assign wr_duty = sel && (|iomem_wstrb) && (idx == 2'd1);
  assign tick    = en && (presc_cnt == presc);
  assign wrap    = tick && (phase == 8'hFF);

  always_comb begin
    shadow_nxt = shadow;
    if (iomem_wstrb[0]) shadow_nxt[7:0]   = iomem_wdata[7:0];
    if (iomem_wstrb[1]) shadow_nxt[15:8]  = iomem_wdata[15:8];
    if (iomem_wstrb[2]) shadow_nxt[23:16] = iomem_wdata[23:16];
  end

  always_comb begin
    rd_mux = 32'h0;
    case (idx)
      2'd0:    rd_mux = {presc, 14'h0, inv, en};
      2'd1:    rd_mux = {8'h0, shadow};
      2'd2:    rd_mux = {15'h0, pend, pcount};
      default: rd_mux = 32'h0;
    endcase
  end

  // Bus stage: ready and read data register one cycle after select
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'h0;
      en          <= 1'b0;
      inv         <= 1'b0;
      presc       <= 16'h0;
      shadow      <= DUTY_RESET;
    end else begin
      iomem_ready <= sel;
      if (sel) iomem_rdata <= rd_mux;
      if (wr_ctrl) begin
        if (iomem_wstrb[0]) {inv, en}    <= iomem_wdata[1:0];
        if (iomem_wstrb[2]) presc[7:0]   <= iomem_wdata[23:16];
        if (iomem_wstrb[3]) presc[15:8]  <= iomem_wdata[31:24];
      end
      if (wr_duty) shadow <= shadow_nxt;
    end
  end

  // Timebase stage: prescaler, phase, period wrap and double-buffered duty
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_cnt <= 16'h0;
      phase     <= 8'h0;
      pcount    <= 16'h0;
      pend      <= 1'b0;
      active    <= DUTY_RESET;
    end else if (!en) begin
      presc_cnt <= 16'h0;
      phase     <= 8'h0;
      pend      <= 1'b0;
      active    <= shadow;
    end else begin
      // A PRESC lowered below presc_cnt lets the count run on through 16'hFFFF
      presc_cnt <= tick ? 16'h0 : presc_cnt + 16'd1;
      if (tick) phase <= phase + 8'd1;
      if (wrap) begin
        pcount <= pcount + 16'd1;
        if (pend) active <= shadow;
      end
      // A duty write coinciding with the wrap keeps PEND set for the next period
      if (wr_duty)   pend <= 1'b1;
      else if (wrap) pend <= 1'b0;
    end
  end

  // Output stage: irq is delayed one extra cycle to line up with the phase-0 outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm_r      <= 1'b0;
      pwm_g      <= 1'b0;
      pwm_b      <= 1'b0;
      wrap_p0    <= 1'b0;
      period_irq <= 1'b0;
    end else begin
      pwm_r      <= en & ((phase < active[7:0])   ^ inv);
      pwm_g      <= en & ((phase < active[15:8])  ^ inv);
      pwm_b      <= en & ((phase < active[23:16]) ^ inv);
      wrap_p0    <= wrap;
      period_irq <= wrap_p0;
    end
  end

endmodule

// File: tb/tb_iomem_rgb_pwm.sv
// Directed bench for iomem_rgb_pwm: register access, duty ratios, double buffering, inversion.
module tb_iomem_rgb_pwm;

  localparam logic [23:0] DRST = 24'h123456;

  logic        clk, resetn;
  logic        iomem_valid, iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;
  logic        pwm_r, pwm_g, pwm_b, period_irq;

  int n_chk = 0;
  int n_fail = 0;

  int q_r[$], q_g[$], q_b[$], q_len[$];
  int cr = 0, cg = 0, cb = 0, cl = 0;

  iomem_rgb_pwm #(.BASE_ADDR(8'h03), .DUTY_RESET(DRST)) dut (
    .clk(clk), .resetn(resetn),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b), .period_irq(period_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-period high counts; a segment starts on each period_irq cycle
  initial forever begin
    @(negedge clk);
    if (period_irq) begin
      q_r.push_back(cr); q_g.push_back(cg); q_b.push_back(cb); q_len.push_back(cl);
      cr = int'(pwm_r); cg = int'(pwm_g); cb = int'(pwm_b); cl = 1;
    end else begin
      cr += int'(pwm_r); cg += int'(pwm_g); cb += int'(pwm_b); cl += 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata);
    bit got = 0;
    @(posedge clk); #1;
    iomem_valid = 1'b1; iomem_addr = addr; iomem_wdata = wdata; iomem_wstrb = wstrb;
    rdata = 32'h0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      if (iomem_ready) begin
        got = 1;
        rdata = iomem_rdata;
      end
    end
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    if (!got) chk("ready_timeout", 32'h0, 32'h1);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    logic [31:0] d;
    bus_xfer(addr, wdata, wstrb, d);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] d);
    bus_xfer(addr, 32'h0, 4'h0, d);
  endtask

  task automatic wait_periods(input int n);
    int target = q_r.size() + n;
    int budget = n * 2200;
    while (q_r.size() < target && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (q_r.size() < target) chk("period_timeout", 32'h0, 32'h1);
  endtask

  task automatic chk_last(input string tag, input int r, input int g, input int b, input int len);
    int k = q_r.size() - 1;
    if (k < 0) begin
      chk({tag, "_empty"}, 32'h0, 32'h1);
    end else begin
      chk({tag, "_r"},   32'(q_r[k]),   32'(r));
      chk({tag, "_g"},   32'(q_g[k]),   32'(g));
      chk({tag, "_b"},   32'(q_b[k]),   32'(b));
      chk({tag, "_len"}, 32'(q_len[k]), 32'(len));
    end
  endtask

  localparam logic [31:0] A_CTRL = 32'h0300_0000;
  localparam logic [31:0] A_DUTY = 32'h0300_0004;
  localparam logic [31:0] A_STAT = 32'h0300_0008;
  localparam logic [31:0] A_RSV  = 32'h0300_000C;

  initial begin
    logic [31:0] d, p1, p2;
    int base, hi, rdy;
    bit got;

    resetn = 1'b0; iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    iomem_addr = 32'h0; iomem_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pwm",   {29'h0, pwm_r, pwm_g, pwm_b}, 32'h0);
    chk("rst_irq",   {31'h0, period_irq}, 32'h0);
    chk("rst_ready", {31'h0, iomem_ready}, 32'h0);
    resetn = 1'b1;

    bus_read(A_CTRL, d); chk("rst_ctrl", d, 32'h0);
    bus_read(A_DUTY, d); chk("rst_duty", d, {8'h0, DRST});
    bus_read(A_STAT, d); chk("rst_stat", d, 32'h0);
    bus_read(A_RSV,  d); chk("rst_rsv",  d, 32'h0);

    // Foreign address must never be acknowledged
    @(posedge clk); #1;
    iomem_valid = 1'b1; iomem_addr = 32'h0400_0000; iomem_wstrb = 4'h0;
    rdy = 0;
    repeat (10) begin
      @(posedge clk); #1;
      rdy += int'(iomem_ready);
    end
    iomem_valid = 1'b0;
    chk("foreign_noack", 32'(rdy), 32'h0);

    // Base ratios, PRESC=0
    bus_write(A_DUTY, 32'h0040_8000, 4'hF);
    bus_write(A_CTRL, 32'h0000_0001, 4'hF);
    bus_read(A_STAT, d); chk("en0_duty_nopend", {31'h0, d[16]}, 32'h0);
    wait_periods(3);
    chk_last("p0", 0, 128, 64, 256);

    // PRESC=3: period 1024, PCOUNT +1 per 1024 clocks
    bus_write(A_DUTY, 32'h0040_8010, 4'hF);
    bus_write(A_CTRL, 32'h0003_0001, 4'hF);
    bus_read(A_CTRL, d); chk("ctrl_presc", d, 32'h0003_0001);
    wait_periods(3);
    chk_last("p3", 64, 512, 256, 1024);
    bus_read(A_STAT, p1);
    repeat (1022) @(posedge clk);
    bus_read(A_STAT, p2);
    chk("pcount_step", {16'h0, p2[15:0] - p1[15:0]}, 32'h1);

    // Mid-period duty change takes effect at the next wrap
    bus_write(A_CTRL, 32'h0000_0000, 4'hF);
    bus_write(A_DUTY, 32'h0040_8080, 4'hF);
    bus_write(A_CTRL, 32'h0000_0001, 4'hF);
    wait_periods(2);
    bus_write(A_DUTY, 32'h0000_0020, 4'h1);
    bus_read(A_STAT, d); chk("pend_set", {31'h0, d[16]}, 32'h1);
    wait_periods(1);
    chk_last("cur_period", 128, 128, 64, 256);
    bus_read(A_STAT, d); chk("pend_clr", {31'h0, d[16]}, 32'h0);
    wait_periods(1);
    chk_last("next_period", 32, 128, 64, 256);

    // Duty write landing exactly on the wrap edge
    got = 0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(posedge clk); #1;
      if (period_irq) got = 1;
    end
    if (!got) chk("irq_timeout", 32'h0, 32'h1);
    bus_write(A_DUTY, 32'h0000_0050, 4'h1);
    repeat (252) @(posedge clk);
    #1;
    iomem_valid = 1'b1; iomem_addr = A_DUTY; iomem_wdata = 32'h0000_0060; iomem_wstrb = 4'h1;
    @(posedge clk); #1;
    chk("wrap_wr_ready", {31'h0, iomem_ready}, 32'h1);
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    base = q_r.size();
    bus_read(A_STAT, d); chk("wrap_wr_pend", {31'h0, d[16]}, 32'h1);
    wait_periods(base + 3 - q_r.size());
    if (q_r.size() >= base + 3) begin
      chk("wrap_before", 32'(q_r[base]),     32'd32);
      chk("wrap_old",    32'(q_r[base + 1]), 32'd80);
      chk("wrap_new",    32'(q_r[base + 2]), 32'd96);
    end

    // Byte strobes, inversion, EN=0
    bus_write(A_DUTY, 32'hFFFF_FFFF, 4'b0010);
    bus_read(A_DUTY, d); chk("strb_g", d, 32'h0040_FF60);
    bus_write(A_DUTY, 32'h0000_0000, 4'h1);
    bus_write(A_CTRL, 32'h0000_0000, 4'hF);
    bus_write(A_CTRL, 32'h0000_0003, 4'hF);
    bus_read(A_CTRL, d); chk("ctrl_inv", d, 32'h0000_0003);
    wait_periods(2);
    chk_last("inv", 256, 1, 192, 256);
    bus_write(A_CTRL, 32'h0000_0002, 4'hF);
    repeat (2) @(posedge clk);
    hi = 0;
    repeat (20) begin
      @(posedge clk); #1;
      hi += int'(pwm_r) + int'(pwm_g) + int'(pwm_b);
    end
    chk("dis_pwm_off", 32'(hi), 32'h0);

    bus_write(A_RSV, 32'hFFFF_FFFF, 4'hF);
    bus_read(A_RSV, d); chk("rsv_read0", d, 32'h0);

    // Asynchronous reset while running
    bus_write(A_CTRL, 32'h0000_0001, 4'hF);
    repeat (5) @(posedge clk);
    #3;
    chk("pre_rst_g", {31'h0, pwm_g}, 32'h1);
    resetn = 1'b0;
    #1;
    chk("async_rst_pwm", {29'h0, pwm_r, pwm_g, pwm_b}, 32'h0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    bus_read(A_CTRL, d); chk("rst2_ctrl", d, 32'h0);
    bus_read(A_DUTY, d); chk("rst2_duty", d, {8'h0, DRST});
    bus_read(A_STAT, d); chk("rst2_stat", d, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
